ex_stage_mc: RTL and testbench
==============================

EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; legal values are 8..64, even.
REQ-002 Parameter OP_W, default 12, one-hot single-cycle ALU opcode width, passed to the existing alu block.
REQ-003 Parameter SIDE_W, default 72, opaque sideband width (pc, rf write info, mem controls, store data), carried unmodified.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 resetn  in  1  reset; synchronous, active-low.
REQ-006 id_to_ex_valid  in  1  upstream offers an instruction.
REQ-007 ex_allowin  out  1  stage accepts an offer this cycle.
REQ-008 id_alu_op  in  OP_W  single-cycle ALU opcode.
REQ-009 id_src1, id_src2  in  DATA_W each  operands; src1 is the dividend and src2 the divisor.
REQ-010 id_div_req  in  1  selects the iterative divider instead of the ALU.
REQ-011 id_div_signed  in  1  selects two's-complement divide.
REQ-012 id_div_rem  in  1  1 returns the remainder, 0 returns the quotient.
REQ-013 id_side  in  SIDE_W  sideband payload.
REQ-014 flush  in  1  kills the instruction held in EX.
REQ-015 mem_allowin  in  1  downstream accepts.
REQ-016 ex_to_mem_valid  out  1  result is offered downstream.
REQ-017 ex_result  out  DATA_W  final result.
REQ-018 ex_side  out  SIDE_W  registered sideband.
REQ-019 ex_fwd_valid  out  1  ex_result is final and may be bypassed to ID.
REQ-020 ex_busy  out  1  divider is in state BUSY.

Function
REQ-021 The capture condition is id_to_ex_valid & ex_allowin & ~flush; on capture the stage SHALL register op, operands, div controls and id_side, and SHALL set ex_valid.
REQ-022 ex_allowin SHALL equal ~ex_valid | (ex_ready_go & mem_allowin).
REQ-023 ex_to_mem_valid SHALL equal ex_valid & ex_ready_go & ~flush.
REQ-024 For a non-divide instruction, ex_ready_go SHALL be 1 and ex_result SHALL be the combinational ALU output, giving zero added latency.
REQ-025 Divider FSM states: IDLE, BUSY, DONE.
- IDLE->BUSY on capture with id_div_req=1.
- BUSY->DONE when the iteration counter reaches 0.
- DONE->IDLE on downstream handshake or flush.
- DONE->BUSY on a handshake in the same cycle as capture of a new divide.
REQ-026 BUSY SHALL run exactly DATA_W cycles of radix-2 restoring division on operand magnitudes, one quotient bit per cycle, with the counter loaded to DATA_W-1 on capture.
REQ-027 For a divide, ex_ready_go SHALL be 1 only in DONE; the first ex_to_mem_valid cycle is therefore DATA_W+1 cycles after the capture edge.
REQ-028 Signed result sign fixes:
- The quotient is negated when the operand signs differ.
- The remainder takes the sign of the dividend.
REQ-029 Divisor 0: quotient SHALL be all ones and remainder SHALL be the dividend, in both signed and unsigned modes; the full DATA_W-cycle latency still applies.
REQ-030 Signed most-negative / -1: quotient SHALL be the most-negative value and remainder SHALL be 0.
REQ-031 Quotient and remainder SHALL be registered in DONE and held stable until the handshake.
REQ-032 ex_fwd_valid SHALL equal ex_valid & ex_ready_go, independent of mem_allowin.
REQ-033 flush SHALL clear ex_valid and return the FSM to IDLE on the next edge; flush in BUSY SHALL abort the division.
REQ-034 flush SHALL block capture of any instruction offered in the same cycle.
REQ-035 While ex_valid & ~ex_ready_go or ~mem_allowin, all held registers SHALL remain unchanged.

Reset
REQ-036 While resetn=0 at a clock edge: ex_valid=0, FSM=IDLE, counter=0, quotient and remainder registers=0.
REQ-037 During reset: ex_to_mem_valid=0, ex_fwd_valid=0, ex_busy=0, ex_allowin=1.
REQ-038 Reset SHALL override flush and capture; a divide in progress SHALL be dropped.
REQ-039 ex_side and the operand registers need no reset value.

Verification (DATA_W=32)
REQ-040 Non-divide throughput: ADD 5+7 on each of 4 consecutive cycles with mem_allowin=1 -> ex_result=12 every cycle, one result per cycle, no bubbles.
REQ-041 Downstream stall: mem_allowin=0 for 3 cycles with ADD held -> ex_allowin=0; ex_result and ex_side stay stable; transfer happens on the first cycle mem_allowin=1.
REQ-042 Unsigned divide: 100/7, quotient and remainder in two runs -> ex_busy=1 for 32 cycles; ex_to_mem_valid rises 33 cycles after capture with results 14 and 2.
REQ-043 Signed divide: -7/2 -> quotient 0xFFFFFFFD and remainder 0xFFFFFFFF; 0x80000000/-1 -> quotient 0x80000000 and remainder 0.
REQ-044 Divisor zero: 0x1234/0 -> quotient 0xFFFFFFFF and remainder 0x1234 after 33 cycles.
REQ-045 Flush: flush at BUSY cycle 10 together with a new ADD offer -> ADD is not captured; next cycle ex_valid=0, ex_busy=0, ex_allowin=1.
REQ-046 Reset mid-divide: resetn=0 at BUSY cycle 5 -> ex_valid=0 and ex_busy=0 after that edge; no result is ever emitted for that divide.

Source files
------------

// File: rtl/ex_stage_mc.sv
// Execute stage: one-hot single-cycle ALU plus a radix-2 restoring divider with a
// valid/allowin pipeline handshake. The ALU decode needs OP_W >= 12.
module ex_stage_mc #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 12,
   parameter int unsigned SIDE_W = 72
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              id_to_ex_valid,
   output logic              ex_allowin,
   input  logic [OP_W-1:0]   id_alu_op,
   input  logic [DATA_W-1:0] id_src1,
   input  logic [DATA_W-1:0] id_src2,
   input  logic              id_div_req,
   input  logic              id_div_signed,
   input  logic              id_div_rem,
   input  logic [SIDE_W-1:0] id_side,
   input  logic              flush,
   input  logic              mem_allowin,
   output logic              ex_to_mem_valid,
   output logic [DATA_W-1:0] ex_result,
   output logic [SIDE_W-1:0] ex_side,
   output logic              ex_fwd_valid,
   output logic              ex_busy
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam int unsigned SH_W  = $clog2(DATA_W);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} div_st_e;

   div_st_e             st_q, st_d;
   logic                ex_valid_q, ex_valid_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   quo_q, rem_q;
   logic [OP_W-1:0]     op_q;
   logic [DATA_W-1:0]   src1_q, src2_q;
   logic                div_req_q, div_signed_q, div_rem_q;
   logic [SIDE_W-1:0]   side_q;
   // Divider working set: partial remainder, dividend/quotient shifter, divisor magnitude.
   logic [DATA_W-1:0]   pr_q, dq_q, dv_q;

   logic                ready_go, capture, handshake, div_last;
   logic [DATA_W:0]     div_tmp;
   logic                div_ge;
   logic [DATA_W-1:0]   div_sub, pr_nxt, dq_nxt, quo_fix, rem_fix;
   logic                neg_quo, neg_rem, div_zero;
   logic [DATA_W-1:0]   alu_res, sra_res;

   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
      return (sgn && x[DATA_W-1]) ? -x : x;
   endfunction

   assign ready_go        = ~div_req_q | (st_q == StDone);
   assign ex_allowin      = ~resetn | ~ex_valid_q | (ready_go & mem_allowin);
   assign ex_to_mem_valid = resetn & ex_valid_q & ready_go & ~flush;
   assign ex_fwd_valid    = resetn & ex_valid_q & ready_go;
   assign ex_busy         = resetn & (st_q == StBusy);
   assign capture         = id_to_ex_valid & ex_allowin & ~flush;
   assign handshake       = ex_to_mem_valid & mem_allowin;
   assign div_last        = (st_q == StBusy) && (cnt_q == '0) && !flush;

   always_comb begin
      ex_valid_d = ex_valid_q;
      if (flush) begin
         ex_valid_d = 1'b0;
      end else if (capture) begin
         ex_valid_d = 1'b1;
      end else if (ready_go && mem_allowin) begin
         ex_valid_d = 1'b0;
      end
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         StIdle: if (capture && id_div_req) st_d = StBusy;
         StBusy: begin
            if (flush) st_d = StIdle;
            else if (cnt_q == '0) st_d = StDone;
         end
         StDone: begin
            if (flush) st_d = StIdle;
            else if (handshake) st_d = (capture && id_div_req) ? StBusy : StIdle;
         end
         default: st_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (capture && id_div_req) begin
         cnt_d = CNT_W'(DATA_W - 1);
      end else if (st_q == StBusy && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // One restoring step: shift the next dividend bit in, subtract if it fits.
   always_comb begin
      div_tmp  = {pr_q, dq_q[DATA_W-1]};
      div_ge   = div_tmp >= {1'b0, dv_q};
      div_sub  = div_tmp[DATA_W-1:0] - dv_q;
      pr_nxt   = div_ge ? div_sub : div_tmp[DATA_W-1:0];
      dq_nxt   = {dq_q[DATA_W-2:0], div_ge};
      div_zero = (src2_q == '0);
      neg_quo  = div_signed_q & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]);
      neg_rem  = div_signed_q & src1_q[DATA_W-1];
      quo_fix  = div_zero ? '1     : (neg_quo ? -dq_nxt : dq_nxt);
      rem_fix  = div_zero ? src1_q : (neg_rem ? -pr_nxt : pr_nxt);
   end

   assign sra_res = $signed(src1_q) >>> src2_q[SH_W-1:0];

   always_comb begin
      alu_res = '0;
      if (op_q[0])  alu_res = alu_res | (src1_q + src2_q);
      if (op_q[1])  alu_res = alu_res | (src1_q - src2_q);
      if (op_q[2])  alu_res = alu_res | {{(DATA_W-1){1'b0}}, $signed(src1_q) < $signed(src2_q)};
      if (op_q[3])  alu_res = alu_res | {{(DATA_W-1){1'b0}}, src1_q < src2_q};
      if (op_q[4])  alu_res = alu_res | (src1_q & src2_q);
      if (op_q[5])  alu_res = alu_res | ~(src1_q | src2_q);
      if (op_q[6])  alu_res = alu_res | (src1_q | src2_q);
      if (op_q[7])  alu_res = alu_res | (src1_q ^ src2_q);
      if (op_q[8])  alu_res = alu_res | (src1_q << src2_q[SH_W-1:0]);
      if (op_q[9])  alu_res = alu_res | (src1_q >> src2_q[SH_W-1:0]);
      if (op_q[10]) alu_res = alu_res | sra_res;
      if (op_q[11]) alu_res = alu_res | src2_q;
   end

   assign ex_result = div_req_q ? (div_rem_q ? rem_q : quo_q) : alu_res;
   assign ex_side   = side_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         st_q       <= StIdle;
         ex_valid_q <= 1'b0;
         cnt_q      <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
      end else begin
         st_q       <= st_d;
         ex_valid_q <= ex_valid_d;
         cnt_q      <= cnt_d;
         if (div_last) begin
            quo_q <= quo_fix;
            rem_q <= rem_fix;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         op_q         <= id_alu_op;
         src1_q       <= id_src1;
         src2_q       <= id_src2;
         div_req_q    <= id_div_req;
         div_signed_q <= id_div_signed;
         div_rem_q    <= id_div_rem;
         side_q       <= id_side;
      end
      if (capture && id_div_req) begin
         pr_q <= '0;
         dq_q <= mag(id_src1, id_div_signed);
         dv_q <= mag(id_src2, id_div_signed);
      end else if (st_q == StBusy) begin
         pr_q <= pr_nxt;
         dq_q <= dq_nxt;
      end
   end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: ALU vector table, stall, divider latency/results,
// back-to-back divides, flush and reset aborts.
module tb_ex_stage_mc;

   localparam int DW = 32;
   localparam int OW = 12;
   localparam int SW = 72;

   localparam logic [OW-1:0] OP_ADD  = 12'h001;
   localparam logic [OW-1:0] OP_SUB  = 12'h002;
   localparam logic [OW-1:0] OP_SLT  = 12'h004;
   localparam logic [OW-1:0] OP_SLTU = 12'h008;
   localparam logic [OW-1:0] OP_AND  = 12'h010;
   localparam logic [OW-1:0] OP_NOR  = 12'h020;
   localparam logic [OW-1:0] OP_OR   = 12'h040;
   localparam logic [OW-1:0] OP_XOR  = 12'h080;
   localparam logic [OW-1:0] OP_SLL  = 12'h100;
   localparam logic [OW-1:0] OP_SRL  = 12'h200;
   localparam logic [OW-1:0] OP_SRA  = 12'h400;
   localparam logic [OW-1:0] OP_LUI  = 12'h800;

   logic          clk = 1'b0;
   logic          resetn;
   logic          id_to_ex_valid;
   logic          ex_allowin;
   logic [OW-1:0] id_alu_op;
   logic [DW-1:0] id_src1, id_src2;
   logic          id_div_req, id_div_signed, id_div_rem;
   logic [SW-1:0] id_side;
   logic          flush;
   logic          mem_allowin;
   logic          ex_to_mem_valid;
   logic [DW-1:0] ex_result;
   logic [SW-1:0] ex_side;
   logic          ex_fwd_valid;
   logic          ex_busy;

   ex_stage_mc #(.DATA_W(DW), .OP_W(OW), .SIDE_W(SW)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .id_to_ex_valid  (id_to_ex_valid),
      .ex_allowin      (ex_allowin),
      .id_alu_op       (id_alu_op),
      .id_src1         (id_src1),
      .id_src2         (id_src2),
      .id_div_req      (id_div_req),
      .id_div_signed   (id_div_signed),
      .id_div_rem      (id_div_rem),
      .id_side         (id_side),
      .flush           (flush),
      .mem_allowin     (mem_allowin),
      .ex_to_mem_valid (ex_to_mem_valid),
      .ex_result       (ex_result),
      .ex_side         (ex_side),
      .ex_fwd_valid    (ex_fwd_valid),
      .ex_busy         (ex_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] exp;
   } alu_vec_t;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          sg;
      logic          rm;
      logic [DW-1:0] exp;
   } div_vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic dreq, input logic dsg, input logic drem,
                        input logic [SW-1:0] side);
      id_to_ex_valid = 1'b1;
      id_alu_op      = op;
      id_src1        = a;
      id_src2        = b;
      id_div_req     = dreq;
      id_div_signed  = dsg;
      id_div_rem     = drem;
      id_side        = side;
   endtask

   task automatic no_offer();
      id_to_ex_valid = 1'b0;
      id_div_req     = 1'b0;
   endtask

   // Called in cycle 1 after the capture edge; returns the cycle index of the first valid.
   task automatic wait_valid(output int lat, output int busy);
      lat  = 1;
      busy = 0;
      while (!ex_to_mem_valid && lat < 100) begin
         if (ex_busy) busy++;
         step();
         lat++;
      end
   endtask

   task automatic watch_no_result(input string name, input int cycles);
      int seen = 0;
      for (int k = 0; k < cycles; k++) begin
         if (ex_to_mem_valid || ex_fwd_valid) seen++;
         step();
      end
      chk(name, seen, 0);
   endtask

   alu_vec_t avec[15];
   div_vec_t dvec[10];

   initial begin
      int lat, busy;

      avec[0]  = '{OP_ADD,  32'd5,        32'd7,        32'd12};
      avec[1]  = '{OP_ADD,  32'd5,        32'd7,        32'd12};
      avec[2]  = '{OP_ADD,  32'd5,        32'd7,        32'd12};
      avec[3]  = '{OP_ADD,  32'd5,        32'd7,        32'd12};
      avec[4]  = '{OP_SUB,  32'd5,        32'd7,        32'hFFFF_FFFE};
      avec[5]  = '{OP_SLT,  32'hFFFF_FFFF, 32'd1,       32'd1};
      avec[6]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0};
      avec[7]  = '{OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
      avec[8]  = '{OP_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF};
      avec[9]  = '{OP_OR,   32'h0000_F0F0, 32'h0F00_0000, 32'h0F00_F0F0};
      avec[10] = '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
      avec[11] = '{OP_SLL,  32'd1,         32'd4,         32'd16};
      avec[12] = '{OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000};
      avec[13] = '{OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000};
      avec[14] = '{OP_LUI,  32'h0,         32'h1234_5000, 32'h1234_5000};

      dvec[0]  = '{32'd100,       32'd7,         1'b0, 1'b0, 32'd14};
      dvec[1]  = '{32'd100,       32'd7,         1'b0, 1'b1, 32'd2};
      dvec[2]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0, 32'hFFFF_FFFD};
      dvec[3]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1, 32'hFFFF_FFFF};
      dvec[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000};
      dvec[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0};
      dvec[6]  = '{32'h1234,      32'h0,         1'b0, 1'b0, 32'hFFFF_FFFF};
      dvec[7]  = '{32'h1234,      32'h0,         1'b0, 1'b1, 32'h1234};
      dvec[8]  = '{32'hFFFF_FFFB, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF};
      dvec[9]  = '{32'hFFFF_FFFF, 32'h10,        1'b0, 1'b1, 32'hF};

      resetn = 1'b0;
      flush = 1'b0;
      mem_allowin = 1'b1;
      id_alu_op = '0;
      id_src1 = '0;
      id_src2 = '0;
      id_div_signed = 1'b0;
      id_div_rem = 1'b0;
      id_side = '0;
      no_offer();
      step();
      step();
      chk("reset to_mem_valid", ex_to_mem_valid, 0);
      chk("reset fwd_valid", ex_fwd_valid, 0);
      chk("reset busy", ex_busy, 0);
      chk("reset allowin", ex_allowin, 1);
      resetn = 1'b1;
      step();
      chk("idle to_mem_valid", ex_to_mem_valid, 0);

      // Back-to-back ALU ops: one result per cycle, no bubbles.
      offer(avec[0].op, avec[0].a, avec[0].b, 1'b0, 1'b0, 1'b0, SW'(100));
      for (int i = 0; i < 15; i++) begin
         step();
         chk($sformatf("alu[%0d] valid", i), ex_to_mem_valid, 1);
         chk($sformatf("alu[%0d] result", i), ex_result, avec[i].exp);
         chk($sformatf("alu[%0d] side", i), ex_side, SW'(100 + i));
         chk($sformatf("alu[%0d] allowin", i), ex_allowin, 1);
         if (i < 14) offer(avec[i+1].op, avec[i+1].a, avec[i+1].b, 1'b0, 1'b0, 1'b0, SW'(101 + i));
         else no_offer();
      end
      step();
      chk("alu drain", ex_to_mem_valid, 0);

      // Downstream stall with a competing offer pending.
      mem_allowin = 1'b0;
      offer(OP_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 72'hAB_CDEF);
      step();
      offer(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 72'h11);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("stall%0d allowin", k), ex_allowin, 0);
         chk($sformatf("stall%0d valid", k), ex_to_mem_valid, 1);
         chk($sformatf("stall%0d result", k), ex_result, 32'd12);
         chk($sformatf("stall%0d side", k), ex_side, 72'hAB_CDEF);
         if (k < 2) step();
      end
      mem_allowin = 1'b1;
      #1;
      chk("release allowin", ex_allowin, 1);
      step();
      no_offer();
      chk("after stall result", ex_result, 32'd2);
      chk("after stall side", ex_side, 72'h11);
      step();
      chk("after stall drain", ex_to_mem_valid, 0);

      // Divides: 32 busy cycles, first valid in cycle 33 (capture edge ends cycle 0).
      for (int i = 0; i < 10; i++) begin
         offer(OP_ADD, dvec[i].a, dvec[i].b, 1'b1, dvec[i].sg, dvec[i].rm, SW'(i));
         step();
         no_offer();
         chk($sformatf("div[%0d] fwd early", i), ex_fwd_valid, 0);
         wait_valid(lat, busy);
         chk($sformatf("div[%0d] latency", i), lat, 33);
         chk($sformatf("div[%0d] busy cycles", i), busy, 32);
         chk($sformatf("div[%0d] result", i), ex_result, dvec[i].exp);
         chk($sformatf("div[%0d] fwd", i), ex_fwd_valid, 1);
         if (i == 0) begin
            // Result held in DONE while downstream stalls.
            mem_allowin = 1'b0;
            step();
            step();
            chk("div hold valid", ex_to_mem_valid, 1);
            chk("div hold result", ex_result, 32'd14);
            chk("div hold fwd", ex_fwd_valid, 1);
            mem_allowin = 1'b1;
         end
         step();
         chk($sformatf("div[%0d] drained", i), ex_to_mem_valid, 0);
      end

      // DONE -> BUSY: new divide captured in the handshake cycle.
      offer(OP_ADD, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0, SW'(0));
      step();
      no_offer();
      wait_valid(lat, busy);
      chk("b2b first result", ex_result, 32'd14);
      offer(OP_ADD, 32'd100, 32'd7, 1'b1, 1'b0, 1'b1, SW'(0));
      step();
      no_offer();
      chk("b2b busy", ex_busy, 1);
      chk("b2b not valid", ex_to_mem_valid, 0);
      wait_valid(lat, busy);
      chk("b2b latency", lat, 33);
      chk("b2b second result", ex_result, 32'd2);
      step();

      // Flush in BUSY cycle 10 together with an ADD offer.
      offer(OP_ADD, 32'h1234, 32'd3, 1'b1, 1'b0, 1'b0, SW'(0));
      step();
      no_offer();
      for (int c = 1; c < 10; c++) step();
      chk("flush pre busy", ex_busy, 1);
      flush = 1'b1;
      offer(OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, SW'(0));
      #1;
      chk("flush to_mem", ex_to_mem_valid, 0);
      step();
      flush = 1'b0;
      no_offer();
      chk("flush busy", ex_busy, 0);
      chk("flush fwd", ex_fwd_valid, 0);
      chk("flush allowin", ex_allowin, 1);
      chk("flush to_mem after", ex_to_mem_valid, 0);
      watch_no_result("flush no result", 40);

      // Reset in BUSY cycle 5.
      offer(OP_ADD, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0, SW'(0));
      step();
      no_offer();
      for (int c = 1; c < 5; c++) step();
      chk("rst pre busy", ex_busy, 1);
      resetn = 1'b0;
      #1;
      chk("rst during busy out", ex_busy, 0);
      chk("rst during allowin", ex_allowin, 1);
      step();
      resetn = 1'b1;
      #1;
      chk("rst busy", ex_busy, 0);
      chk("rst fwd", ex_fwd_valid, 0);
      chk("rst allowin", ex_allowin, 1);
      watch_no_result("rst no result", 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
